// File: rtl/ship_motion_ctrl.sv
// ship_motion_ctrl: per-frame horizontal ship motion with boundary clamp, fire cooldown and shot launch.
// Define SHIP_INERTIA_EN for accelerating/braking motion; by default velocity jumps straight to its target.
module ship_motion_ctrl #(
    parameter int INITIAL_X      = 280,
    parameter int INITIAL_Y      = 400,
    parameter int LEFT_BOUNDARY  = 5,
    parameter int RIGHT_BOUNDARY = 570,
    parameter int FP_SHIFT       = 6,
    parameter int MAX_SPEED      = 256,
    parameter int ACCEL          = 32,
    parameter int FIRE_COOLDOWN  = 15,
    parameter int SHIP_WIDTH     = 64
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               gameActive,
    input  logic               RightMove,
    input  logic               LeftMove,
    input  logic               FireReq,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic signed [10:0] velocityX,
    output logic               shotPulse,
    output logic signed [10:0] shotX,
    output logic [1:0]         moveState
);
    typedef enum logic [1:0] {IDLE = 2'd0, MOVE_R = 2'd1, MOVE_L = 2'd2, BRAKE = 2'd3} state_t;

    localparam int CW = FIRE_COOLDOWN > 0 ? $clog2(FIRE_COOLDOWN + 1) : 1;
    localparam logic [CW-1:0] CD_LOAD = CW'(FIRE_COOLDOWN);
    localparam logic signed [31:0] X_RST = 32'(INITIAL_X) <<< FP_SHIFT;
    localparam logic signed [31:0] X_MIN = 32'(LEFT_BOUNDARY) <<< FP_SHIFT;
    localparam logic signed [31:0] X_MAX = 32'(RIGHT_BOUNDARY) <<< FP_SHIFT;
    localparam logic signed [31:0] V_MAX = 32'(MAX_SPEED);
`ifdef SHIP_INERTIA_EN
    localparam logic signed [31:0] V_ACC = 32'(ACCEL);
`endif

    logic signed [31:0] x_q, x_d, vel_w, vel_n, pos_n;
    logic signed [10:0] vel_q, vel_d, shotx_q, shotx_d;
    logic [CW-1:0]      cd_q, cd_d;
    logic               shot_q, shot_d, upd, right_only, left_only;
    state_t             state_q, state_d, state_n;

    assign upd        = startOfFrame & gameActive;
    assign right_only = RightMove & ~LeftMove;
    assign left_only  = LeftMove & ~RightMove;
    assign vel_w      = 32'(vel_q);

    always_comb begin
        vel_n   = '0;
        state_n = IDLE;
`ifdef SHIP_INERTIA_EN
        if (right_only) begin
            vel_n   = (vel_w + V_ACC > V_MAX) ? V_MAX : vel_w + V_ACC;
            state_n = MOVE_R;
        end else if (left_only) begin
            vel_n   = (vel_w - V_ACC < -V_MAX) ? -V_MAX : vel_w - V_ACC;
            state_n = MOVE_L;
        end else begin
            // brake toward zero, landing exactly on zero rather than crossing it
            vel_n   = vel_w > V_ACC ? vel_w - V_ACC : vel_w < -V_ACC ? vel_w + V_ACC : '0;
            state_n = vel_n != '0 ? BRAKE : IDLE;
        end
`else
        vel_n   = right_only ? V_MAX : left_only ? -V_MAX : '0;
        state_n = right_only ? MOVE_R : left_only ? MOVE_L : IDLE;
`endif
    end

    always_comb begin
        pos_n   = x_q + vel_n;
        x_d     = x_q;
        vel_d   = vel_q;
        state_d = state_q;
        cd_d    = cd_q;
        shot_d  = 1'b0;
        shotx_d = shotx_q;
        if (upd) begin
            x_d     = pos_n;
            vel_d   = 11'(vel_n);
            state_d = state_n;
            if (pos_n < X_MIN || pos_n > X_MAX) begin
                x_d     = pos_n < X_MIN ? X_MIN : X_MAX;
                vel_d   = '0;
                state_d = IDLE;
            end
            // shot origin uses the position before this frame's move
            if (FireReq && cd_q == '0) begin
                shot_d  = 1'b1;
                shotx_d = topLeftX + 11'(SHIP_WIDTH / 2);
                cd_d    = CD_LOAD;
            end else if (cd_q != '0) begin
                cd_d = cd_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            x_q     <= X_RST;
            vel_q   <= '0;
            state_q <= IDLE;
            cd_q    <= '0;
            shot_q  <= 1'b0;
            shotx_q <= '0;
        end else begin
            x_q     <= x_d;
            vel_q   <= vel_d;
            state_q <= state_d;
            cd_q    <= cd_d;
            shot_q  <= shot_d;
            shotx_q <= shotx_d;
        end
    end

    assign topLeftX  = x_q[FP_SHIFT +: 11];
    assign topLeftY  = 11'(INITIAL_Y);
    assign velocityX = vel_q;
    assign shotPulse = shot_q;
    assign shotX     = shotx_q;
    assign moveState = state_q;
endmodule

// File: tb/tb_ship_motion_ctrl.sv
// tb_ship_motion_ctrl: directed scenarios plus random frames against a frame-level reference model.
module tb_ship_motion_ctrl;
    localparam int FP = 6, VMAX = 256, ACC = 32, CD = 15;
    localparam int X0 = 280 * 64, XL = 5 * 64, XR = 570 * 64;

    logic clk = 1'b0;
    logic resetN, startOfFrame, gameActive, RightMove, LeftMove, FireReq;
    logic signed [10:0] topLeftX, topLeftY, velocityX, shotX;
    logic shotPulse;
    logic [1:0] moveState;

    int n_chk = 0, n_err = 0;
    int m_x, m_v, m_st, m_cd, m_shot, m_shotx;
    int frame_no;
    int shots[$];

    ship_motion_ctrl dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .gameActive(gameActive),
        .RightMove(RightMove), .LeftMove(LeftMove), .FireReq(FireReq),
        .topLeftX(topLeftX), .topLeftY(topLeftY), .velocityX(velocityX),
        .shotPulse(shotPulse), .shotX(shotX), .moveState(moveState)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_x = X0; m_v = 0; m_st = 0; m_cd = 0; m_shot = 0; m_shotx = 0;
    endfunction

    function automatic void model_step();
        int nv, nx, st;
        bit r, l;
        r = RightMove && !LeftMove;
        l = LeftMove && !RightMove;
        m_shot = 0;
        if (startOfFrame && gameActive) begin
            if (FireReq && m_cd == 0) begin
                m_shot = 1; m_shotx = (m_x >>> FP) + 32; m_cd = CD;
            end else if (m_cd > 0) m_cd--;
`ifdef SHIP_INERTIA_EN
            if (r) nv = (m_v + ACC > VMAX) ? VMAX : m_v + ACC;
            else if (l) nv = (m_v - ACC < -VMAX) ? -VMAX : m_v - ACC;
            else if (m_v > 0) nv = (m_v > ACC) ? m_v - ACC : 0;
            else nv = (m_v < -ACC) ? m_v + ACC : 0;
            st = r ? 1 : l ? 2 : (nv != 0) ? 3 : 0;
`else
            nv = r ? VMAX : l ? -VMAX : 0;
            st = r ? 1 : l ? 2 : 0;
`endif
            nx = m_x + nv;
            if (nx < XL || nx > XR) begin
                nx = (nx < XL) ? XL : XR; nv = 0; st = 0;
            end
            m_x = nx; m_v = nv; m_st = st;
        end
    endfunction

    task automatic chk_all();
        chk("topLeftX", int'(topLeftX), m_x >>> FP);
        chk("topLeftY", int'(topLeftY), 400);
        chk("velocityX", int'(velocityX), m_v);
        chk("moveState", int'(moveState), m_st);
        chk("shotPulse", int'(shotPulse), m_shot);
        chk("shotX", int'(shotX), m_shotx);
    endtask

    task automatic step();
        @(posedge clk);
        if (resetN) model_step();
        #1;
        chk_all();
        if (shotPulse) shots.push_back(frame_no);
    endtask

    task automatic frame(input bit r, input bit l, input bit f, input bit ga);
        RightMove = r; LeftMove = l; FireReq = f; gameActive = ga; startOfFrame = 1'b1;
        frame_no++;
        step();
        startOfFrame = 1'b0;
        step();
    endtask

    task automatic do_reset();
        #2 resetN = 1'b0;
        #1 model_reset();
        chk_all();
        @(posedge clk);
        #1 chk_all();
        #2 resetN = 1'b1;
    endtask

    initial begin
        {startOfFrame, gameActive, RightMove, LeftMove, FireReq} = '0;
        resetN = 1'b1;
        #1 resetN = 1'b0;
        model_reset();
        #2 chk_all();
        @(posedge clk);
        #1 resetN = 1'b1;
        chk("rst_x", int'(topLeftX), 280);

`ifdef SHIP_INERTIA_EN
        for (int i = 0; i < 8; i++) frame(1, 0, 0, 1);
        chk("hold8_vel", int'(velocityX), 256);
        chk("hold8_x", int'(topLeftX), 298);
        chk("hold8_state", int'(moveState), 1);
        frame(1, 1, 0, 1);
        chk("brake_vel", int'(velocityX), 224);
        chk("brake_state", int'(moveState), 3);
        frame(1, 1, 0, 0);
        chk("frozen_vel", int'(velocityX), 224);
        for (int i = 0; i < 7; i++) frame(1, 1, 0, 1);
        chk("braked_vel", int'(velocityX), 0);
        chk("braked_state", int'(moveState), 0);
`else
        frame(1, 0, 0, 1);
        chk("r1_x", int'(topLeftX), 284);
        chk("r1_vel", int'(velocityX), 256);
        frame(0, 0, 0, 1);
        chk("rel_vel", int'(velocityX), 0);
        chk("rel_state", int'(moveState), 0);
        chk("rel_x", int'(topLeftX), 284);
        frame(1, 0, 0, 0);
        chk("frozen_x", int'(topLeftX), 284);
`endif

        do_reset();
        for (int i = 0; i < 100; i++) begin
            frame(0, 1, 0, 1);
            chk("min_x", int'(topLeftX >= 11'sd5), 1);
        end
        chk("left_x", int'(topLeftX), 5);
        chk("left_vel", int'(velocityX), 0);
        chk("left_state", int'(moveState), 0);

        do_reset();
        shots.delete();
        frame_no = 0;
        for (int i = 0; i < 40; i++) begin
            frame(0, 0, 1, 1);
            if (i == 0) chk("shotx_312", int'(shotX), 312);
        end
        chk("shot_count", shots.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("shot_frame%0d", i), (i < shots.size()) ? shots[i] : -1, 1 + 16 * i);

        do_reset();
        frame(0, 0, 1, 1);
        for (int i = 0; i < 8; i++) frame(1, 0, 0, 1);
        do_reset();
        chk("mid_rst_x", int'(topLeftX), 280);
        chk("mid_rst_vel", int'(velocityX), 0);
        shots.delete();
        frame(0, 0, 1, 1);
        chk("fire_after_rst", shots.size(), 1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) RightMove = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) LeftMove = 1'($urandom_range(0, 1));
            FireReq = 1'($urandom_range(0, 1));
            startOfFrame = ($urandom_range(0, 2) == 0);
            gameActive = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 399) == 0) do_reset();
            else step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
